pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Second-generation control unit for the 5-stage MIPS pipeline. It decodes the ID-stage opcode (extended ISA: R-type, addi, andi, ori, slti, lw, sw, beq, bne, j) and owns the ID/EX, EX/MEM and MEM/WB control-bundle registers. It also holds load-use hazard detection (stall plus bubble) and branch/jump redirect and flush generation. The datapath keeps only data pipeline registers; all control bits come from this block.

Parameters:
ALUOP_W, 3, ALU operation field width; must be >= 3.
REG_ADDR_W, 5, register-specifier width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
op_i  in  6  opcode of the IF/ID instruction.
rs_i  in  REG_ADDR_W  rs of the IF/ID instruction.
rt_i  in  REG_ADDR_W  rt of the IF/ID instruction.
id_valid_i  in  1  IF/ID holds a real instruction.
regs_equal_i  in  1  ID-stage comparator result, rs value == rt value.
pc_write_o  out  1  PC update enable (0 = hold).
ifid_write_o  out  1  IF/ID load enable (0 = hold).
flush_o  out  1  clear IF/ID on the next edge.
jump_o  out  1  select jump target for the PC.
branch_taken_o  out  1  select branch target for the PC.
illegal_o  out  1  unknown opcode in ID (combinational).
ex_ctrl_o  out  ALUOP_W+2  {ALUSrc, ALUOp, RegDst}, from ID/EX.
mem_ctrl_o  out  2  {MemRead, MemWrite}, from EX/MEM.
wb_ctrl_o  out  2  {RegWrite, MemtoReg}, from MEM/WB.

Behaviour:
- Polarity is unchanged from the current unit. ALUSrc=1 selects the register operand, 0 selects the immediate. RegDst=0 selects rd, 1 selects rt.
- ALUOp codes: 000 add (addi/lw/sw), 001 sub (beq/bne), 010 funct (R-type), 011 and (andi), 100 or (ori), 101 slt (slti). The codes are zero-extended to ALUOP_W.
- Decode table (ALUSrc, RegDst, MemRead, MemWrite, RegWrite, MemtoReg):
  - R-type: 1,0,0,0,1,0
  - addi/andi/ori/slti: 0,1,0,0,1,0
  - lw: 0,1,1,0,1,1
  - sw: 0,0,0,1,0,0
  - beq/bne: 1,0,0,0,0,0
  - j: all zero
  - No output is ever X.
- Unknown opcode: decodes to an all-zero bundle and illegal_o=1 while it sits in ID with id_valid_i=1.
- Bubble means an all-zero bundle. id_valid_i=0 decodes as a bubble.
- Pipeline: on each edge ID/EX <= decoded bundle (or a bubble), EX/MEM <= ID/EX, MEM/WB <= EX/MEM. Latency from ID to ex_ctrl_o, mem_ctrl_o and wb_ctrl_o is 1, 2 and 3 cycles respectively. EX/MEM and MEM/WB are never stalled.
- The block stores idex_rt (rt of the ID/EX instruction) alongside idex_memread.
- Load-use hazard: load_use = idex_memread & id_valid_i & (idex_rt==rs_i | (uses_rt & idex_rt==rt_i)).
  - uses_rt is true for R-type, sw, beq and bne.
  - On load_use: pc_write_o=0, ifid_write_o=0, ID/EX loads a bubble. Stall length is exactly one cycle, because the bubble clears idex_memread.
- Redirect (only when load_use=0 and id_valid_i=1):
  - jump_o=1 for j.
  - branch_taken_o=1 for beq & regs_equal_i, or bne & !regs_equal_i.
  - flush_o = jump_o | branch_taken_o.
  - The branch or jump itself enters ID/EX with its decoded bundle, which has no writes.
- Stall and branch in the same cycle: the stall wins. flush_o, jump_o and branch_taken_o are all 0, and the branch is re-evaluated next cycle.
- Default outputs: pc_write_o=1, ifid_write_o=1, flush_o=0.
- Reset: all three stage registers, idex_rt and the counters are cleared. Outputs after reset: ex_ctrl_o=0, mem_ctrl_o=0, wb_ctrl_o=0.
- Reset asserted mid-stall or mid-flush: the next edge clears state. Combinational outputs follow the inputs with the cleared state, so no stall is possible in the first post-reset cycle.

Optional Feature:
PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0]. Each increments once per cycle in which load_use or flush_o is asserted. Both wrap at 2^32-1 to 0 and are cleared by rst_i.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - opcode localparams
  - ALUOp code localparams
  - bundle field widths and bit positions
  - the all-zero BUBBLE constant
- Sub-module pipe_ctrl_decode: the purely combinational opcode to bundle decoder plus illegal flag and uses_rt. The top level holds the registers, hazard and redirect logic.

Test Plan:
- Reset, then op_i=R-type with id_valid_i=1:
  - cycle+1: ex_ctrl_o={1,010,0}
  - cycle+2: mem_ctrl_o=00
  - cycle+3: wb_ctrl_o=10
- lw with rt=5, then add with rs=5 in ID:
  - pc_write_o=0, ifid_write_o=0 for exactly one cycle
  - next ex_ctrl_o=0 (bubble)
  - the add issues the following cycle
- lw rt=5, then sw with rt=5 and rs=3: stall (uses_rt). Same case with addi rt=5 as consumer and rs=3: no stall.
- beq with regs_equal_i=1: branch_taken_o=1 and flush_o=1 for one cycle. bne with regs_equal_i=1: neither asserts. j: jump_o=1 and flush_o=1.
- Load-use hazard coinciding with a taken beq: flush_o=0 on the stall cycle, flush_o=1 on the next cycle.
- op_i=6'b111111: illegal_o=1 and ex_ctrl_o=0 one cycle later. With PIPE_CTRL_PERF_EN, 3 stalls and 2 flushes give stall_cnt_o=3 and flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: opcodes, ALUOp codes and the
// bit layout of the control bundle {ALUSrc, ALUOp, RegDst, MemRead, MemWrite, RegWrite, MemtoReg}.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int ALUOP_CODE_W = 3;
    localparam logic [ALUOP_CODE_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_CODE_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_CODE_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_CODE_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_CODE_W-1:0] ALU_OR    = 3'b100;
    localparam logic [ALUOP_CODE_W-1:0] ALU_SLT   = 3'b101;

    // Low fields sit at fixed positions; ALUSrc floats above the ALUOp field.
    localparam int WB_W         = 2;
    localparam int MEM_W        = 2;
    localparam int WB_LSB       = 0;
    localparam int MEMTOREG_BIT = 0;
    localparam int REGWRITE_BIT = 1;
    localparam int MEM_LSB      = 2;
    localparam int MEMWRITE_BIT = 2;
    localparam int MEMREAD_BIT  = 3;
    localparam int EX_LSB       = 4;
    localparam int REGDST_BIT   = 4;
    localparam int ALUOP_LSB    = 5;

    function automatic int bundle_w(input int aluop_w);
        return aluop_w + 6;
    endfunction

    localparam int MAX_BUNDLE_W = 64;
    localparam logic [MAX_BUNDLE_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder: control bundle, illegal-opcode flag and whether
// the instruction reads rt as a source operand.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         op_i,
    input  logic               valid_i,
    output logic [ALUOP_W+5:0] bundle_o,
    output logic               illegal_o,
    output logic               uses_rt_o
);

    logic                    alu_src;
    logic                    reg_dst;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic                    known;
    logic [ALUOP_CODE_W-1:0] alu_code;
    logic [ALUOP_W-1:0]      aluop_ext;

    always_comb begin
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        known      = 1'b1;
        uses_rt_o  = 1'b0;
        alu_code   = ALU_ADD;
        case (op_i)
            OP_RTYPE: begin
                alu_src   = 1'b1;
                alu_code  = ALU_FUNCT;
                reg_write = 1'b1;
                uses_rt_o = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                if (op_i == OP_ANDI)      alu_code = ALU_AND;
                else if (op_i == OP_ORI)  alu_code = ALU_OR;
                else if (op_i == OP_SLTI) alu_code = ALU_SLT;
            end
            OP_LW: begin
                reg_dst    = 1'b1;
                mem_read   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                mem_write = 1'b1;
                uses_rt_o = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_src   = 1'b1;
                alu_code  = ALU_SUB;
                uses_rt_o = 1'b1;
            end
            OP_J: ;
            default: known = 1'b0;
        endcase

        aluop_ext = '0;
        aluop_ext[ALUOP_CODE_W-1:0] = alu_code;

        // Empty slots and unknown opcodes both travel down the pipe as a bubble.
        bundle_o = BUBBLE[ALUOP_W+5:0];
        if (valid_i && known) begin
            bundle_o[ALUOP_LSB+ALUOP_W]         = alu_src;
            bundle_o[ALUOP_LSB +: ALUOP_W]      = aluop_ext;
            bundle_o[REGDST_BIT]                = reg_dst;
            bundle_o[MEMREAD_BIT]               = mem_read;
            bundle_o[MEMWRITE_BIT]              = mem_write;
            bundle_o[REGWRITE_BIT]              = reg_write;
            bundle_o[MEMTOREG_BIT]              = mem_to_reg;
        end
        illegal_o = valid_i & ~known;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decode, ID/EX..MEM/WB control registers, load-use stall and
// branch/jump redirect. Define PIPE_CTRL_PERF_EN to add stall/flush event counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5:0]            op_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic                  id_valid_i,
    input  logic                  regs_equal_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  flush_o,
    output logic                  jump_o,
    output logic                  branch_taken_o,
    output logic                  illegal_o,
    output logic [ALUOP_W+1:0]    ex_ctrl_o,
    output logic [MEM_W-1:0]      mem_ctrl_o,
    output logic [WB_W-1:0]       wb_ctrl_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    localparam int BW = bundle_w(ALUOP_W);

    logic [BW-1:0]            dec_bundle;
    logic                     uses_rt;
    logic [BW-1:0]            idex_d;
    logic [BW-1:0]            idex_q;
    logic [MEM_W+WB_W-1:0]    exmem_q;
    logic [WB_W-1:0]          memwb_q;
    logic [REG_ADDR_W-1:0]    idex_rt_q;
    logic                     load_use;
    logic                     redirect_ok;

    pipe_ctrl_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .op_i      (op_i),
        .valid_i   (id_valid_i),
        .bundle_o  (dec_bundle),
        .illegal_o (illegal_o),
        .uses_rt_o (uses_rt)
    );

    always_comb begin
        load_use = idex_q[MEMREAD_BIT] & id_valid_i &
                   ((idex_rt_q == rs_i) | (uses_rt & (idex_rt_q == rt_i)));
        // A stall suppresses redirect; the held branch is re-evaluated next cycle.
        redirect_ok    = id_valid_i & ~load_use;
        jump_o         = redirect_ok & (op_i == OP_J);
        branch_taken_o = redirect_ok & (((op_i == OP_BEQ) & regs_equal_i) |
                                        ((op_i == OP_BNE) & ~regs_equal_i));
        flush_o        = jump_o | branch_taken_o;
        pc_write_o     = ~load_use;
        ifid_write_o   = ~load_use;
        idex_d         = load_use ? BUBBLE[BW-1:0] : dec_bundle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            idex_rt_q <= '0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= idex_q[WB_LSB +: MEM_W+WB_W];
            memwb_q   <= exmem_q[WB_LSB +: WB_W];
            idex_rt_q <= rt_i;
        end
    end

    assign ex_ctrl_o  = idex_q[BW-1:EX_LSB];
    assign mem_ctrl_o = exmem_q[MEM_LSB +: MEM_W];
    assign wb_ctrl_o  = memwb_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_d;
    logic [31:0] flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, load_use};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_o};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios followed by random
// instruction streams compared against a behavioural model of the control rules.
module tb_pipe_ctrl_unit;

    localparam int AW = 3;
    localparam int RW = 5;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_SLTI = 6'b001010;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic [5:0]    op_i = '0;
    logic [RW-1:0] rs_i = '0;
    logic [RW-1:0] rt_i = '0;
    logic          id_valid_i = 1'b0;
    logic          regs_equal_i = 1'b0;
    logic          pc_write_o, ifid_write_o, flush_o, jump_o, branch_taken_o, illegal_o;
    logic [AW+1:0] ex_ctrl_o;
    logic [1:0]    mem_ctrl_o;
    logic [1:0]    wb_ctrl_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

    pipe_ctrl_unit #(.ALUOP_W(AW), .REG_ADDR_W(RW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .op_i           (op_i),
        .rs_i           (rs_i),
        .rt_i           (rt_i),
        .id_valid_i     (id_valid_i),
        .regs_equal_i   (regs_equal_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .flush_o        (flush_o),
        .jump_o         (jump_o),
        .branch_taken_o (branch_taken_o),
        .illegal_o      (illegal_o),
        .ex_ctrl_o      (ex_ctrl_o),
        .mem_ctrl_o     (mem_ctrl_o),
        .wb_ctrl_o      (wb_ctrl_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    // reference model
    typedef struct packed {
        logic          alusrc;
        logic [AW-1:0] aluop;
        logic          regdst;
        logic          mr, mw, rw, m2r;
    } ctl_t;

    typedef struct packed {
        ctl_t ctl;
        logic legal;
        logic uses_rt;
    } dec_t;

    function automatic dec_t ref_decode(input logic [5:0] op);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            T_R:    begin d.ctl = '{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; d.uses_rt = 1'b1; end
            T_ADDI: d.ctl = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            T_ANDI: d.ctl = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            T_ORI:  d.ctl = '{1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            T_SLTI: d.ctl = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            T_LW:   d.ctl = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            T_SW:   begin d.ctl = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; d.uses_rt = 1'b1; end
            T_BEQ, T_BNE: begin d.ctl = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; d.uses_rt = 1'b1; end
            T_J:    d.ctl = '0;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // stage[0]=ID/EX, stage[1]=EX/MEM, stage[2]=MEM/WB
    ctl_t          stage [3];
    logic [RW-1:0] m_rt;
    logic [31:0]   m_scnt, m_fcnt;

    // scoreboard
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) stage[i] = '0;
        m_rt   = '0;
        m_scnt = '0;
        m_fcnt = '0;
    endtask

    task automatic check_regs();
        check("ex_ctrl", 32'(ex_ctrl_o), 32'({stage[0].alusrc, stage[0].aluop, stage[0].regdst}));
        check("mem_ctrl", 32'(mem_ctrl_o), 32'({stage[1].mr, stage[1].mw}));
        check("wb_ctrl", 32'(wb_ctrl_o), 32'({stage[2].rw, stage[2].m2r}));
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cnt", stall_cnt_o, m_scnt);
        check("flush_cnt", flush_cnt_o, m_fcnt);
`endif
    endtask

    // driver: one ID-stage cycle, combinational checks then registered checks
    task automatic cyc(input logic [5:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic v, input logic eq, output logic stalled, output logic flushed);
        dec_t d;
        logic lu, jmp, bt;
        ctl_t nxt;
        @(negedge clk);
        op_i = op; rs_i = rs; rt_i = rt; id_valid_i = v; regs_equal_i = eq;
        #1;
        d   = ref_decode(op);
        lu  = stage[0].mr && v && ((m_rt == rs) || (d.uses_rt && (m_rt == rt)));
        jmp = !lu && v && (op == T_J);
        bt  = !lu && v && (((op == T_BEQ) && eq) || ((op == T_BNE) && !eq));
        check("pc_write", 32'(pc_write_o), 32'(!lu));
        check("ifid_write", 32'(ifid_write_o), 32'(!lu));
        check("jump", 32'(jump_o), 32'(jmp));
        check("branch_taken", 32'(branch_taken_o), 32'(bt));
        check("flush", 32'(flush_o), 32'(jmp || bt));
        check("illegal", 32'(illegal_o), 32'(v && !d.legal));
        nxt = (lu || !v || !d.legal) ? '0 : d.ctl;
        if (lu) m_scnt++;
        if (jmp || bt) m_fcnt++;
        @(posedge clk);
        #1;
        stage[2] = stage[1];
        stage[1] = stage[0];
        stage[0] = nxt;
        m_rt = rt;
        check_regs();
        stalled = lu;
        flushed = jmp || bt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_clear();
        check_regs();
    endtask

    logic [5:0] ops [10];
    logic st, fl;

    initial begin
        logic [5:0]    p_op;
        logic [RW-1:0] p_rs, p_rt;
        logic          p_v;
        ops = '{T_R, T_ADDI, T_ANDI, T_ORI, T_SLTI, T_LW, T_SW, T_BEQ, T_BNE, T_J};
        model_clear();
        do_reset();

        // R-type through all three stages
        cyc(T_R, 5'd1, 5'd2, 1'b1, 1'b0, st, fl);
        check("rtype_ex", 32'(ex_ctrl_o), 32'(5'b1_010_0));
        cyc(T_R, 5'd0, 5'd0, 1'b0, 1'b0, st, fl);
        check("rtype_mem", 32'(mem_ctrl_o), 32'(2'b00));
        cyc(T_R, 5'd0, 5'd0, 1'b0, 1'b0, st, fl);
        check("rtype_wb", 32'(wb_ctrl_o), 32'(2'b10));

        // load-use on rs: one stall cycle, bubble, then the add issues
        cyc(T_LW, 5'd1, 5'd5, 1'b1, 1'b0, st, fl);
        cyc(T_R, 5'd5, 5'd6, 1'b1, 1'b0, st, fl);
        check("lu_rs_stall", 32'(st), 32'(1));
        check("lu_bubble", 32'(ex_ctrl_o), 32'(0));
        cyc(T_R, 5'd5, 5'd6, 1'b1, 1'b0, st, fl);
        check("lu_rs_release", 32'(st), 32'(0));
        check("lu_add_issue", 32'(ex_ctrl_o), 32'(5'b1_010_0));

        // rt dependence only matters for consumers that read rt
        cyc(T_LW, 5'd1, 5'd5, 1'b1, 1'b0, st, fl);
        cyc(T_SW, 5'd3, 5'd5, 1'b1, 1'b0, st, fl);
        check("lu_sw_stall", 32'(st), 32'(1));
        cyc(T_SW, 5'd3, 5'd5, 1'b1, 1'b0, st, fl);
        cyc(T_LW, 5'd1, 5'd5, 1'b1, 1'b0, st, fl);
        cyc(T_ADDI, 5'd3, 5'd5, 1'b1, 1'b0, st, fl);
        check("lu_addi_nostall", 32'(st), 32'(0));

        // redirects
        cyc(T_BEQ, 5'd1, 5'd2, 1'b1, 1'b1, st, fl);
        check("beq_taken", 32'(fl), 32'(1));
        cyc(T_R, 5'd0, 5'd0, 1'b0, 1'b0, st, fl);
        cyc(T_BNE, 5'd1, 5'd2, 1'b1, 1'b1, st, fl);
        check("bne_not_taken", 32'(fl), 32'(0));
        cyc(T_J, 5'd0, 5'd0, 1'b1, 1'b0, st, fl);
        check("j_taken", 32'(fl), 32'(1));
        cyc(T_R, 5'd0, 5'd0, 1'b0, 1'b0, st, fl);

        // stall wins over a taken branch, branch redirects on the retry
        cyc(T_LW, 5'd1, 5'd5, 1'b1, 1'b0, st, fl);
        cyc(T_BEQ, 5'd5, 5'd2, 1'b1, 1'b1, st, fl);
        check("stall_beq_noflush", 32'(fl), 32'(0));
        cyc(T_BEQ, 5'd5, 5'd2, 1'b1, 1'b1, st, fl);
        check("stall_beq_retry", 32'(fl), 32'(1));

        // illegal opcode
        cyc(6'b111111, 5'd1, 5'd2, 1'b1, 1'b0, st, fl);
        check("illegal_bubble", 32'(ex_ctrl_o), 32'(0));

        // reset while a load sits in ID/EX: no stall right after reset
        cyc(T_LW, 5'd1, 5'd5, 1'b1, 1'b0, st, fl);
        do_reset();
        cyc(T_R, 5'd5, 5'd5, 1'b1, 1'b0, st, fl);
        check("post_reset_nostall", 32'(st), 32'(0));

        // three stalls and two flushes from a clean reset
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(T_LW, 5'd1, 5'd7, 1'b1, 1'b0, st, fl);
            cyc(T_R, 5'd7, 5'd2, 1'b1, 1'b0, st, fl);
            cyc(T_R, 5'd7, 5'd2, 1'b1, 1'b0, st, fl);
        end
        cyc(T_J, 5'd0, 5'd0, 1'b1, 1'b0, st, fl);
        cyc(T_BNE, 5'd1, 5'd2, 1'b1, 1'b0, st, fl);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall3", stall_cnt_o, 32'd3);
        check("perf_flush2", flush_cnt_o, 32'd2);
`endif

        // random instruction stream with realistic IF/ID hold and flush
        p_op = T_R; p_rs = '0; p_rt = '0; p_v = 1'b0;
        fl = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            cyc(p_op, p_rs, p_rt, p_v, 1'($urandom_range(0, 1)), st, fl);
            if (!st) begin
                p_op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
                p_rs = RW'($urandom_range(0, 3));
                p_rt = RW'($urandom_range(0, 3));
                p_v  = fl ? 1'b0 : ($urandom_range(0, 7) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
